// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Adds two WIDTH-bit operands one nibble per clock through a single 4-bit
//   ripple-carry slice (rca_4bit). The carry is held in a register between
//   cycles, so a WIDTH-bit add takes WIDTH/4 cycles after the accepting edge.
//
// Parameters:
//   WIDTH  operand/result width, multiple of 4 and >= 4 (default 16)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request an addition, sampled only while idle
//   a, b   operands, latched on the accepting edge
//   cin    carry-in, latched on the accepting edge
//   busy   high whenever the adder is not idle
//   done   one-cycle pulse, s/cout valid
//   s      registered sum
//   cout   registered final carry-out
//   ovf    registered signed overflow (present only with NSA_OVERFLOW_EN)
//
// Optional feature macro: NSA_OVERFLOW_EN adds the ovf output.

module rca_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic c;

    always_comb begin
        s = '0;
        c = cin;
        for (int unsigned i = 0; i < 4; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef NSA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic             carry_reg;
    logic [IW-1:0]    idx;
    logic [3:0]       nib_a, nib_b, nib_s;
    logic             nib_cout;
    logic             last_nib;

    assign nib_a    = a_reg[4*idx +: 4];
    assign nib_b    = b_reg[4*idx +: 4];
    assign last_nib = (idx == IW'(NIB - 1));

    rca_4bit u_rca (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_reg),
        .s    (nib_s),
        .cout (nib_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ADD;
            ADD:     if (last_nib) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            s         <= '0;
            cout      <= 1'b0;
`ifdef NSA_OVERFLOW_EN
            ovf       <= 1'b0;
`endif
        end else if (state == IDLE && start) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx       <= '0;
            s         <= '0;
        end else if (state == ADD) begin
            s[4*idx +: 4] <= nib_s;
            carry_reg     <= nib_cout;
            idx           <= idx + 1'b1;
            if (last_nib) begin
                cout <= nib_cout;
`ifdef NSA_OVERFLOW_EN
                // nib_s[3] is the sum MSB being written this edge, so the
                // carry into the MSB is recovered from it before it lands in s.
                ovf  <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ nib_s[3] ^ nib_cout;
`endif
            end
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] s;
`ifdef NSA_OVERFLOW_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout)
`ifdef NSA_OVERFLOW_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase counts cycles since acceptance; the whole sum is
    // computed arithmetically at acceptance and revealed 4 bits per cycle.
    int           phase = 0;
    logic [W:0]   m_sum = '0;
    logic [W-1:0] m_a = '0, m_b = '0, m_s = '0;
    logic         m_cout = 1'b0, m_ovf = 1'b0;
    logic [W-1:0] ones = '1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase  = 0;
            m_s    = '0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
        end else if (phase == 0) begin
            if (start === 1'b1) begin
                m_a   = a;
                m_b   = b;
                m_sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                m_s   = '0;
                phase = 1;
            end
        end else if (phase <= NIB) begin
            m_s = m_sum[W-1:0] & (ones >> (W - 4 * phase));
            if (phase == NIB) begin
                m_cout = m_sum[W];
                m_ovf  = (m_a[W-1] == m_b[W-1]) && (m_sum[W-1] != m_a[W-1]);
            end
            phase++;
        end else begin
            phase = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {{W{1'b0}}, busy}, {{W{1'b0}}, (phase != 0)});
            chk("done", {{W{1'b0}}, done}, {{W{1'b0}}, (phase == NIB + 1)});
            chk("s", {1'b0, s}, {1'b0, m_s});
            if (phase == 0 || phase == NIB + 1) begin
                chk("cout", {{W{1'b0}}, cout}, {{W{1'b0}}, m_cout});
`ifdef NSA_OVERFLOW_EN
                chk("ovf", {{W{1'b0}}, ovf}, {{W{1'b0}}, m_ovf});
`endif
            end
        end
    end

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) chk({nm, "_idle_timeout"}, {{W{1'b0}}, busy}, '0);
    endtask

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                         input logic [W-1:0] es, input logic ec, input logic eo,
                         input string nm);
        int n = 0;
        wait_idle(nm);
        @(negedge clk);
        a = ta; b = tb_; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, (W+1)'(n), (W+1)'(NIB));
        chk({nm, "_s"}, {1'b0, s}, {1'b0, es});
        chk({nm, "_cout"}, {{W{1'b0}}, cout}, {{W{1'b0}}, ec});
        chk({nm, "_model_s"}, {m_cout, m_s}, {ec, es});
`ifdef NSA_OVERFLOW_EN
        chk({nm, "_ovf"}, {{W{1'b0}}, ovf}, {{W{1'b0}}, eo});
`else
        if (eo === 1'bx) chk({nm, "_eo"}, '0, '1);
`endif
        @(negedge clk);
        chk({nm, "_busy_after"}, {{W{1'b0}}, busy}, '0);
    endtask

    initial begin
        int ndone;
        logic [W-1:0] got;

        // Reset with arbitrary inputs
        a = 16'hBEEF; b = 16'hCAFE; cin = 1'b1; start = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_s", {1'b0, s}, '0);
        chk("rst_cout", {{W{1'b0}}, cout}, '0);
        chk("rst_busy", {{W{1'b0}}, busy}, '0);
        chk("rst_done", {{W{1'b0}}, done}, '0);
        start = 1'b0;
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_stay_idle", {{W{1'b0}}, busy}, '0);

        do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "basic");
        do_op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, "chain");

        // Start while busy must be ignored
        wait_idle("busy_start");
        @(negedge clk);
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; start = 1'b1;
        ndone = 0;
        got = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                got = s;
            end
            start = (i == 1);
            if (i == 1) begin
                a = 16'h0001; b = 16'h0001;
            end
        end
        chk("busy_start_ndone", (W+1)'(ndone), (W+1)'(1));
        chk("busy_start_s", {1'b0, got}, {1'b0, 16'h0100});

        // Reset mid-operation
        wait_idle("mid_rst");
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_s", {1'b0, s}, '0);
        chk("mid_rst_cout", {{W{1'b0}}, cout}, '0);
        chk("mid_rst_busy", {{W{1'b0}}, busy}, '0);
        chk("mid_rst_done", {{W{1'b0}}, done}, '0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        do_op(16'h0003, 16'h0004, 1'b1, 16'h0008, 1'b0, 1'b0, "after_rst");

        // Signed overflow cases
        do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_pos");
        do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "ovf_wrap");
        do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "ovf_neg");

        // Random traffic, start toggling freely including while busy
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            a     = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
            b     = W'($urandom);
            cin   = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
